// File: rtl/poly_horner_eval.sv
// rtl/poly_horner_eval.sv - Horner-method unsigned polynomial evaluator with sticky overflow
module poly_horner_eval #(
    parameter int W   = 16,
    parameter int XW  = 8,
    parameter int DEG = 3,
    localparam int DW = $clog2(DEG + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [XW-1:0]        X,
    input  logic [(DEG+1)*W-1:0] coef,
    input  logic [DW-1:0]        deg,
    output logic                 busy,
    output logic                 done,
    output logic                 Overflow,
    output logic [W-1:0]         Resultado
);

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         s_q, s_d;
    logic [W-1:0]         x_q, x_d;
    logic [(DEG+1)*W-1:0] coef_q, coef_d;
    logic [DW-1:0]        idx_q, idx_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [DW-1:0]        n_eff;
    logic [W-1:0]         c_n;
    logic [W-1:0]         c_prev;
    logic [2*W-1:0]       prod;
    logic [W:0]           sum;

    always_comb begin
        n_eff = (deg > DW'(DEG)) ? DW'(DEG) : deg;
    end

    // c_n comes from the live inputs (capture edge); c_(i-1) from the captured copy.
    always_comb begin
        c_n    = '0;
        c_prev = '0;
        for (int k = 0; k <= DEG; k++) begin
            if (n_eff == DW'(k)) c_n = coef[k*W +: W];
        end
        for (int k = 1; k <= DEG; k++) begin
            if (idx_q == DW'(k)) c_prev = coef_q[(k-1)*W +: W];
        end
    end

    always_comb begin
        prod = {{W{1'b0}}, s_q} * {{W{1'b0}}, x_q};
        sum  = {1'b0, s_q} + {1'b0, c_prev};
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        x_d     = x_q;
        coef_d  = coef_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = W'(X);
                    coef_d  = coef;
                    idx_d   = n_eff;
                    s_d     = c_n;
                    ovf_d   = 1'b0;
                    state_d = (n_eff != '0) ? MUL : DONE;
                end
            end
            MUL: begin
                s_d     = prod[W-1:0];
                ovf_d   = ovf_q | (prod[2*W-1:W] != '0);
                state_d = ADD;
            end
            ADD: begin
                s_d     = sum[W-1:0];
                ovf_d   = ovf_q | sum[W];
                idx_d   = idx_q - 1'b1;
                state_d = (idx_q > DW'(1)) ? MUL : DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            x_q     <= '0;
            coef_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            x_q     <= x_d;
            coef_q  <= coef_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Overflow  = ovf_q;
    assign Resultado = s_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// tb/tb_poly_horner_eval.sv - directed and random checks of poly_horner_eval against a polynomial model
module tb_poly_horner_eval;

    localparam int W   = 16;
    localparam int XW  = 8;
    localparam int DEG = 3;
    localparam int DW  = $clog2(DEG + 1);

    typedef logic [W-1:0] coef_t [DEG+1];

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [XW-1:0]        X;
    logic [(DEG+1)*W-1:0] coef;
    logic [DW-1:0]        deg;
    logic                 busy;
    logic                 done;
    logic                 Overflow;
    logic [W-1:0]         Resultado;

    int errors = 0;
    int checks = 0;

    poly_horner_eval #(.W(W), .XW(XW), .DEG(DEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .coef      (coef),
        .deg       (deg),
        .busy      (busy),
        .done      (done),
        .Overflow  (Overflow),
        .Resultado (Resultado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result from the power-sum form; overflow from the step-by-step Horner rule.
    function automatic void model(input coef_t c, input longint x, input int n,
                                  output longint res, output bit ovf);
        longint m = longint'(1) << W;
        longint p = 1;
        longint acc;
        res = 0;
        for (int i = 0; i <= n; i++) begin
            res = (res + longint'(c[i]) * p) % m;
            p   = p * x;
        end
        ovf = 1'b0;
        acc = longint'(c[n]);
        for (int k = n - 1; k >= 0; k--) begin
            acc = acc * x;
            if (acc >= m) ovf = 1'b1;
            acc = acc % m;
            acc = acc + longint'(c[k]);
            if (acc >= m) ovf = 1'b1;
            acc = acc % m;
        end
    endfunction

    // Entered #1 after a rising edge with the DUT idle.
    task automatic run_eval(input string tag, input int x, input coef_t c, input int deg_in,
                            input bit perturb, input bit spam);
        int     n = (deg_in > DEG) ? DEG : deg_in;
        longint exp_res;
        bit     exp_ovf;
        int     dones = 0;
        int     seen = -1;
        bit     busy_ok = 1'b1;
        model(c, longint'(x), n, exp_res, exp_ovf);
        X   = XW'(x);
        for (int i = 0; i <= DEG; i++) coef[i*W +: W] = c[i];
        deg   = DW'(deg_in);
        start = 1'b1;
        @(posedge clk); #1;
        start = spam;
        chk({tag, "_busy_e0"}, busy, 1);
        chk({tag, "_s_e0"}, Resultado, c[n]);
        chk({tag, "_ovf_e0"}, Overflow, 0);
        for (int k = 0; k <= 2*n + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (done) begin
                dones++;
                if (seen < 0) begin
                    seen = k;
                    chk({tag, "_res"}, Resultado, exp_res);
                    chk({tag, "_ovf"}, Overflow, exp_ovf);
                end
            end
            if (k <= 2*n && !busy) busy_ok = 1'b0;
            if (perturb || spam) begin
                X    = XW'($urandom);
                coef = {$urandom, $urandom};
                deg  = DW'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, seen, 2*n);
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_busy_span"}, busy_ok, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        if (spam) begin
            @(posedge clk); #1;
            chk({tag, "_no_restart"}, busy, 0);
            chk({tag, "_hold_res"}, Resultado, exp_res);
        end
    endtask

    initial begin
        coef_t c;
        rst   = 1'b1;
        start = 1'b0;
        X     = '0;
        coef  = '0;
        deg   = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_res", Resultado, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        c = '{16'd1, 16'd2, 16'd3, 16'd0};
        run_eval("basic", 5, c, 2, 1'b0, 1'b0);
        chk("basic_86", Resultado, 86);

        c = '{16'd0, 16'd0, 16'd0, 16'd1};
        run_eval("wrap", 255, c, 3, 1'b0, 1'b0);
        chk("wrap_767", Resultado, 767);
        chk("wrap_ovf1", Overflow, 1);
        c = '{16'd1, 16'd1, 16'd0, 16'd0};
        run_eval("clear", 2, c, 1, 1'b0, 1'b0);
        chk("clear_3", Resultado, 3);

        c = '{16'h1234, 16'h5555, 16'h6666, 16'h7777};
        run_eval("deg0", 9, c, 0, 1'b0, 1'b0);
        chk("deg0_val", Resultado, 16'h1234);

        c = '{16'd7, 16'd11, 16'd13, 16'd17};
        run_eval("degmax", 3, c, DEG, 1'b0, 1'b0);
        chk("degmax_val", Resultado, 17*27 + 13*9 + 11*3 + 7);

        run_eval("spam", 3, c, 3, 1'b0, 1'b1);
        run_eval("perturb", 6, c, 3, 1'b1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i <= DEG; i++)
                c[i] = (t % 2 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            run_eval("rand", int'($urandom_range(0, (1 << XW) - 1)), c,
                     int'($urandom_range(0, DEG)), t[2], 1'b0);
        end

        c = '{16'd4, 16'd3, 16'd2, 16'd1};
        X = 8'd7;
        for (int i = 0; i <= DEG; i++) coef[i*W +: W] = c[i];
        deg   = DW'(3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf", Overflow, 0);
        chk("mid_rst_res", Resultado, 0);
        @(posedge clk); #1;
        chk("mid_rst_hold_done", done, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", busy, 0);
        c = '{16'd1, 16'd2, 16'd3, 16'd0};
        run_eval("post_rst", 5, c, 2, 1'b0, 1'b0);
        chk("post_rst_86", Resultado, 86);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/poly_horner_eval.md
# poly_horner_eval

- Parametrised polynomial evaluator: computes `c_deg*x^deg + ... + c1*x + c0` by Horner's method.
- Contains an unsigned add/multiply datapath with an accumulator register and its own control FSM, so no external controller is needed.
- Generalises the fixed 16-bit, 8-bit-X operative block to configurable data width, X width and degree, adding a runtime degree select, a start/busy/done handshake and a sticky overflow flag.
- Sits between the top-level sequencer, which supplies operands and `start`, and any consumer of `Resultado`.

## Interface
- `W`, default 16: data/coefficient/result width in bits.
- `XW`, default 8: width of input X. `XW <= W` is required.
- `DEG`, default 3: maximum polynomial degree, must be ≥1. `DW = clog2(DEG+1)`.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request evaluation; sampled only in IDLE.
- `X` input XW: evaluation point, zero-extended to W.
- `coef` input (DEG+1)*W: coefficient i occupies `coef[i*W +: W]`, unsigned.
- `deg` input DW: runtime degree; values > DEG are treated as DEG.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse; `Resultado` is final while it is high.
- `Overflow` output 1: sticky; set if any operation of the current evaluation overflowed W bits.
- `Resultado` output W: accumulator register S, driven directly.

## Operation
- States: IDLE, MUL, ADD, DONE.
- **IDLE**, on `start`=1 at an edge:
  - Capture X, all coefficients, and the effective degree n into an internal index i.
  - S ← c_n; Overflow ← 0; i ← n.
  - Next state is MUL if n>0, else DONE.
- **IDLE** with `start`=0: hold; S and Overflow keep their last values.
- **MUL**: S ← low W bits of S*X. Overflow |= (upper W bits of the 2W product ≠ 0). Next state ADD.
- **ADD**: S ← low W bits of S + c_(i-1). Overflow |= carry-out. i ← i-1. Next state MUL if i-1>0, else DONE.
- **DONE**: `done`=1 for exactly this cycle, then IDLE. S and Overflow hold until the next accepted start.
- `start` outside IDLE (MUL, ADD or DONE) is ignored and not queued.
- Inputs X, `coef` and `deg` may change freely after the capture edge without affecting the evaluation in progress.
- All arithmetic is unsigned. Results wrap modulo 2^W; overflow is only flagged, never saturated.
- Reset (at any time, including mid-evaluation):
  - state=IDLE, S=0, i=0, captured operands=0.
  - `busy`=0, `done`=0, `Overflow`=0, `Resultado`=0.
  - The evaluation in progress is abandoned.
  - Release of reset takes effect asynchronously; the first accepted start is at the first rising edge after `rst` falls.

## Timing
- Call the start-capture edge E0.
- After E0: `busy`=1, `Resultado`=c_n.
- Each Horner step takes 2 cycles (MUL, ADD).
- DONE is entered after edge E(2n). `done` is high in the cycle between E(2n) and E(2n+1).
  - n=0: `done` is high in the cycle immediately after E0.
- Returns to IDLE after E(2n+1). The next start can be accepted at E(2n+2) at the earliest, giving a throughput of one evaluation per 2n+2 cycles.
- `Resultado` changes during an evaluation (intermediate values visible). It is valid only from `done` until the next accepted start.
- `busy`, `done`, `Overflow` and `Resultado` are all registered outputs; none has a combinational path from inputs.

## Test plan
- Basic evaluation. W=16, XW=8, deg=2, c2=3, c1=2, c0=1, X=5, pulse start:
  - `done` is high in the 5th cycle after E0 (between E4 and E5).
  - `Resultado`=86, `Overflow`=0.
  - `busy` is high from E0 through E5.
- Overflow wrap. deg=3, c3=1, c2=c1=c0=0, X=255:
  - `Resultado`=767 (16581375 mod 65536), `Overflow`=1 at `done`.
  - Then start deg=1, c1=1, c0=1, X=2: `Overflow` clears at E0; result 3, `Overflow`=0.
- Degree 0 and clamp:
  - deg=0, c0=0x1234: `done` is high the cycle after E0, result 0x1234.
  - With DEG=3, drive `deg`=3 (max) and an out-of-range value if DW allows. Both must match the deg=3 result.
- Start while busy. Start a deg=3 evaluation, then reassert `start` with different operands during MUL, ADD and DONE:
  - The first result is unaffected.
  - Exactly one `done` pulse.
  - No second evaluation begins without a fresh start in IDLE.
- Operand stability. Change X, `coef` and `deg` every cycle after E0: the result equals the value computed from the operands captured at E0.
- Reset mid-operation. Assert `rst` asynchronously between clock edges during ADD of a deg=3 run:
  - All outputs go to 0 immediately.
  - No `done` pulse.
  - After release, a new start evaluates correctly (the basic-evaluation case gives 86).
